ray_generator: RTL

Upstream stage of the 32-lane ray unit. Walks a frame in raster order, issues one primary ray per pixel: a shared camera origin, an incrementally stepped direction, and the pixel's frame-buffer address. Issues over the ray unit's `start`/`ready` handshake. Drains outstanding work at frame end, then pulses `done` so the frame controller can swap buffers.

---
 rtl/ray_generator_if.sv | 19 +
 rtl/ray_generator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ray_generator_if.sv
`default_nettype none
// =============================================================================
// ray_generator_if : ray issue handshake and payload toward the ray unit -- rev 1.0
// =============================================================================
interface ray_generator_if #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32
);
  logic                           start;
  logic                           ready;
  logic                           unitBusy;
  logic [2:0][POSITION_WIDTH-1:0] rayQ;
  logic [2:0][POSITION_WIDTH-1:0] rayV;
  logic [ADDRESS_WIDTH-1:0]       pixelAddress;

  modport master (output start, rayQ, rayV, pixelAddress, input ready, unitBusy);
  modport slave  (input start, rayQ, rayV, pixelAddress, output ready, unitBusy);
endinterface
`default_nettype wire

// File: rtl/ray_generator.sv
`default_nettype none
// =============================================================================
// ray_generator : raster-order primary ray issuer; macro RAYGEN_STALL_COUNT_EN -- rev 1.0
// =============================================================================
module ray_generator #(
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int PIXEL_STRIDE   = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frameStart,
  input  logic                           flush,
  input  logic [2:0][POSITION_WIDTH-1:0] cameraQ,
  input  logic [2:0][POSITION_WIDTH-1:0] dirTopLeft,
  input  logic [2:0][POSITION_WIDTH-1:0] dirStepX,
  input  logic [2:0][POSITION_WIDTH-1:0] dirStepY,
  input  logic [ADDRESS_WIDTH-1:0]       frameBase,
  ray_generator_if.master                ray,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    stallCycles
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0]            c_x_last = XW'(WIDTH - 1);
  localparam logic [YW-1:0]            c_y_last = YW'(HEIGHT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_stride = ADDRESS_WIDTH'(PIXEL_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         r_state;
  logic                           r_busy;
  logic                           r_done;
  logic [XW-1:0]                  r_x;
  logic [YW-1:0]                  r_y;
  logic [1:0]                     r_drain_cnt;
  logic [2:0][POSITION_WIDTH-1:0] r_ray_q;
  logic [2:0][POSITION_WIDTH-1:0] r_ray_v;
  logic [2:0][POSITION_WIDTH-1:0] r_row_v;
  logic [2:0][POSITION_WIDTH-1:0] r_step_x;
  logic [2:0][POSITION_WIDTH-1:0] r_step_y;
  logic [ADDRESS_WIDTH-1:0]       r_addr;
  logic                           w_handshake;

  // A flush cycle never offers a ray, so an abort cannot race a final handshake.
  assign w_handshake      = (r_state == S_ISSUE) && ray.ready && !flush;
  assign ray.start        = w_handshake;
  assign ray.rayQ         = r_ray_q;
  assign ray.rayV         = r_ray_v;
  assign ray.pixelAddress = r_addr;
  assign busy             = r_busy;
  assign done             = r_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_drain_cnt <= '0;
      r_ray_q     <= '0;
      r_ray_v     <= '0;
      r_row_v     <= '0;
      r_step_x    <= '0;
      r_step_y    <= '0;
      r_addr      <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frameStart) begin
            r_ray_q  <= cameraQ;
            r_ray_v  <= dirTopLeft;
            r_row_v  <= dirTopLeft;
            r_step_x <= dirStepX;
            r_step_y <= dirStepY;
            r_addr   <= frameBase;
            r_x      <= '0;
            r_y      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_handshake) begin
            r_addr <= r_addr + c_stride;
            if (r_x != c_x_last) begin
              r_x <= r_x + XW'(1);
              for (int i = 0; i < 3; i++) r_ray_v[i] <= r_ray_v[i] + r_step_x[i];
            end else if (r_y != c_y_last) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
              for (int i = 0; i < 3; i++) begin
                r_row_v[i] <= r_row_v[i] + r_step_y[i];
                r_ray_v[i] <= r_row_v[i] + r_step_y[i];
              end
            end else begin
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Downstream busy takes two cycles to reflect the last accepted ray.
          if (r_drain_cnt != 2'd2) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end else if (!ray.unitBusy) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAYGEN_STALL_COUNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if ((r_state == S_IDLE) && frameStart && !flush) begin
      r_stall <= '0;
    end else if ((r_state == S_ISSUE) && !ray.ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stallCycles = r_stall;
`else
  assign stallCycles = '0;
`endif

endmodule
`default_nettype wire
